// File: rtl/add16_accumulator.sv
// rtl/add16_accumulator.sv - burst accumulator for the 16-bit adder result stream
//
// Purpose:
//   Accepts {cout, sum, overflow} beats from the registered adder.
//   Accumulates each beat into a wide running total.
//   When a burst closes, presents one result word with status flags.
//   A burst closes on in_last, or automatically on beat MAX_BEATS.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     input beat present
//   in_ready     block can accept a beat (decoded from state only)
//   in_sum       adder sum, WIDTH bits
//   in_cout      adder carry-out, forms bit WIDTH of the beat value
//   in_overflow  adder signed-overflow flag
//   in_last      final beat of the burst
//   out_valid    result word present
//   out_ready    downstream accepts the result
//   out_total    accumulated total, modulo 2^ACC_WIDTH
//   out_count    number of beats in the burst
//   out_wrap     accumulator carried out of its top bit at least once
//   out_ovf_seen at least one beat in the burst had in_overflow set

module add16_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_cout,
    input  logic                 in_overflow,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_total,
    output logic [7:0]           out_count,
    output logic                 out_wrap,
    output logic                 out_ovf_seen
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]           state;
    logic [ACC_WIDTH-1:0] acc;
    logic [7:0]           count;
    logic                 wrap;
    logic                 ovf;

    logic [ACC_WIDTH:0]   beat_ext;
    logic [ACC_WIDTH:0]   add_full;
    logic [8:0]           count_next;
    logic                 accept;
    logic                 closing;

    // The beat value is the unsigned {cout, sum}, zero-extended.
    // One extra top bit catches the accumulator carry-out for the wrap flag.
    assign beat_ext   = {{(ACC_WIDTH - WIDTH){1'b0}}, in_cout, in_sum};
    assign add_full   = {1'b0, acc} + beat_ext;
    assign count_next = {1'b0, count} + 9'd1;

    // Reaching MAX_BEATS closes the burst whatever in_last says.
    assign closing  = in_last | (count_next == 9'(MAX_BEATS));

    // Handshakes are decoded from the state register alone.
    // This leaves no combinational path from out_ready to in_ready.
    assign in_ready  = (state != S_HOLD);
    assign out_valid = (state == S_HOLD);
    assign accept    = in_valid & in_ready;

    assign out_total    = acc;
    assign out_count    = count;
    assign out_wrap     = wrap;
    assign out_ovf_seen = ovf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            acc   <= '0;
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_ACC: begin
                    if (accept) begin
                        acc   <= add_full[ACC_WIDTH-1:0];
                        count <= count_next[7:0];
                        wrap  <= wrap | add_full[ACC_WIDTH];
                        ovf   <= ovf | in_overflow;
                        state <= closing ? S_HOLD : S_ACC;
                    end
                end
                S_HOLD: begin
                    // The result stays frozen until it is taken.
                    // Clearing here lets the next burst start from zero.
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                        wrap  <= 1'b0;
                        ovf   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add16_accumulator.sv
// tb/tb_add16_accumulator.sv - self-checking bench for add16_accumulator

module tb_add16_accumulator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [15:0] in_sum;
    logic        in_cout;
    logic        in_overflow;
    logic        in_last;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_wrap, a_out_ovf;
    logic [31:0] a_out_total;
    logic [7:0]  a_out_count;

    logic        b_in_ready, b_out_valid, b_out_wrap, b_out_ovf;
    logic [19:0] b_out_total;
    logic [7:0]  b_out_count;

    // Both instances share the input stream; only the accumulator width differs.
    add16_accumulator u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_overflow(in_overflow),
        .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_total(a_out_total), .out_count(a_out_count),
        .out_wrap(a_out_wrap), .out_ovf_seen(a_out_ovf)
    );

    add16_accumulator #(.ACC_WIDTH(20)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sum(in_sum), .in_cout(in_cout), .in_overflow(in_overflow),
        .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_total(b_out_total), .out_count(b_out_count),
        .out_wrap(b_out_wrap), .out_ovf_seen(b_out_ovf)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: the unbounded sum of beat values in the current burst.
    // Modular totals and wrap flags for each width are derived from it.
    longint m_sum;
    int     m_count;
    bit     m_ovf;
    bit     m_closed;

    task automatic model_clear();
        m_sum    = 0;
        m_count  = 0;
        m_ovf    = 0;
        m_closed = 0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic put_beat(input logic [15:0] s, input logic c, input logic o, input logic l);
        int waited = 0;
        in_valid    = 1'b1;
        in_sum      = s;
        in_cout     = c;
        in_overflow = o;
        in_last     = l;
        while (a_in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (waited >= 20) begin
            n_fails++;
            $display("FAIL put_beat_timeout: in_ready=%b required 1", a_in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (waited < 20) begin
            m_sum    += longint'({c, s});
            m_count  += 1;
            m_ovf    |= o;
            m_closed  = l || (m_count == 16);
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_sum = '0; in_cout = 1'b0;
        in_overflow = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        n_checks++; if (a_in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
        n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_checks++; if (a_out_total !== 32'h0) begin n_fails++; $display("FAIL reset_total: got %h want 0", a_out_total); end
        n_checks++; if (a_out_count !== 8'h0) begin n_fails++; $display("FAIL reset_count: got %0d want 0", a_out_count); end
        n_checks++; if (a_out_wrap !== 1'b0) begin n_fails++; $display("FAIL reset_wrap: got %b want 0", a_out_wrap); end
        n_checks++; if (a_out_ovf !== 1'b0) begin n_fails++; $display("FAIL reset_ovf: got %b want 0", a_out_ovf); end
        n_checks++; if (b_out_total !== 20'h0) begin n_fails++; $display("FAIL reset_total_b: got %h want 0", b_out_total); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        put_beat(16'h1234, 1'b0, 1'b0, 1'b1);
        n_checks++; if (a_out_valid !== 1'b1) begin n_fails++; $display("FAIL single_valid: got %b want 1", a_out_valid); end
        n_checks++; if (a_out_total !== 32'h0000_1234) begin n_fails++; $display("FAIL single_total: got %h want 00001234", a_out_total); end
        n_checks++; if (a_out_count !== 8'd1) begin n_fails++; $display("FAIL single_count: got %0d want 1", a_out_count); end
        n_checks++; if ({a_out_wrap, a_out_ovf} !== 2'b00) begin n_fails++; $display("FAIL single_flags: got %b want 00", {a_out_wrap, a_out_ovf}); end
        take_result();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) put_beat(16'hFFFF, 1'b1, 1'b0, i == 2);
        n_checks++; if (a_out_valid !== 1'b1) begin n_fails++; $display("FAIL b2b_valid: got %b want 1", a_out_valid); end
        n_checks++; if (a_out_total !== 32'h0005_FFFD) begin n_fails++; $display("FAIL b2b_total: got %h want 0005FFFD", a_out_total); end
        n_checks++; if (a_out_count !== 8'd3) begin n_fails++; $display("FAIL b2b_count: got %0d want 3", a_out_count); end
        take_result();
        // Next burst starts from zero, with out_ready held high throughout.
        out_ready = 1'b1;
        put_beat(16'h0002, 1'b0, 1'b0, 1'b1);
        n_checks++; if (a_out_total !== 32'h2) begin n_fails++; $display("FAIL b2b_fresh_total: got %h want 2", a_out_total); end
        n_checks++; if (a_out_valid !== 1'b1) begin n_fails++; $display("FAIL b2b_fresh_valid: got %b want 1", a_out_valid); end
        @(negedge clk);
        n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_hold_one_cycle: got %b want 0", a_out_valid); end
        n_checks++; if (a_out_count !== 8'd0) begin n_fails++; $display("FAIL b2b_cleared_count: got %0d want 0", a_out_count); end
        out_ready = 1'b0;
        model_clear();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) put_beat(16'h0010, 1'b0, i == 1, i == 3);
        n_checks++; if (a_out_total !== 32'h40) begin n_fails++; $display("FAIL ovf_total: got %h want 40", a_out_total); end
        n_checks++; if (a_out_ovf !== 1'b1) begin n_fails++; $display("FAIL ovf_seen: got %b want 1", a_out_ovf); end
        n_checks++; if (a_out_count !== 8'd4) begin n_fails++; $display("FAIL ovf_count: got %0d want 4", a_out_count); end
        take_result();
        put_beat(16'h0010, 1'b0, 1'b0, 1'b1);
        n_checks++; if (a_out_ovf !== 1'b0) begin n_fails++; $display("FAIL ovf_next_burst: got %b want 0", a_out_ovf); end
        n_checks++; if (a_out_total !== 32'h10) begin n_fails++; $display("FAIL ovf_next_total: got %h want 10", a_out_total); end
        take_result();
    endtask

    task automatic test_auto_close();
        for (int i = 0; i < 16; i++) begin
            put_beat(16'h0001, 1'b0, 1'b0, 1'b0);
            if (i == 14) begin
                n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL auto_early_close: got %b want 0", a_out_valid); end
            end
        end
        n_checks++; if (a_out_valid !== 1'b1) begin n_fails++; $display("FAIL auto_valid: got %b want 1", a_out_valid); end
        n_checks++; if (a_out_total !== 32'h10) begin n_fails++; $display("FAIL auto_total: got %h want 10", a_out_total); end
        n_checks++; if (a_out_count !== 8'd16) begin n_fails++; $display("FAIL auto_count: got %0d want 16", a_out_count); end
        take_result();
        for (int i = 0; i < 16; i++) put_beat(16'hFFFF, 1'b1, 1'b0, 1'b0);
        n_checks++; if (b_out_total !== 20'hF_FFF0) begin n_fails++; $display("FAIL auto_total_w20: got %h want FFFF0", b_out_total); end
        n_checks++; if (b_out_wrap !== 1'b1) begin n_fails++; $display("FAIL auto_wrap_w20: got %b want 1", b_out_wrap); end
        n_checks++; if (a_out_total !== 32'h001F_FFF0) begin n_fails++; $display("FAIL auto_total_w32: got %h want 001FFFF0", a_out_total); end
        n_checks++; if (a_out_wrap !== 1'b0) begin n_fails++; $display("FAIL auto_wrap_w32: got %b want 0", a_out_wrap); end
        take_result();
    endtask

    task automatic test_backpressure();
        put_beat(16'h0003, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b1; in_sum = 16'h0007; in_cout = 1'b0; in_overflow = 1'b0; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (a_in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, a_in_ready); end
            n_checks++; if (a_out_valid !== 1'b1 || a_out_total !== 32'h3 || a_out_count !== 8'd1) begin
                n_fails++;
                $display("FAIL bp_stable[%0d]: got v=%b t=%h c=%0d want v=1 t=3 c=1", i, a_out_valid, a_out_total, a_out_count);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fails++; $display("FAIL bp_release: got v=%b r=%b want v=0 r=1", a_out_valid, a_in_ready); end
        n_checks++; if (a_out_count !== 8'd0) begin n_fails++; $display("FAIL bp_no_consume: got count %0d want 0", a_out_count); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (a_out_valid !== 1'b1 || a_out_total !== 32'h7 || a_out_count !== 8'd1) begin
            n_fails++;
            $display("FAIL bp_held_beat: got v=%b t=%h c=%0d want v=1 t=7 c=1", a_out_valid, a_out_total, a_out_count);
        end
        take_result();
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 2; i++) put_beat(16'h0100, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        n_checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_fails++; $display("FAIL rstmid_handshake: got r=%b v=%b want r=1 v=0", a_in_ready, a_out_valid); end
        n_checks++; if (a_out_total !== 32'h0 || a_out_count !== 8'd0) begin n_fails++; $display("FAIL rstmid_data: got t=%h c=%0d want 0 0", a_out_total, a_out_count); end
        n_checks++; if (a_out_wrap !== 1'b0 || a_out_ovf !== 1'b0) begin n_fails++; $display("FAIL rstmid_flags: got w=%b o=%b want 0 0", a_out_wrap, a_out_ovf); end
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        put_beat(16'h0005, 1'b0, 1'b0, 1'b1);
        n_checks++; if (a_out_total !== 32'h5 || a_out_count !== 8'd1) begin n_fails++; $display("FAIL rstmid_new_burst: got t=%h c=%0d want 5 1", a_out_total, a_out_count); end
        n_checks++; if (a_out_ovf !== 1'b0) begin n_fails++; $display("FAIL rstmid_new_ovf: got %b want 0", a_out_ovf); end
        take_result();
    endtask

    task automatic test_random_bursts();
        logic [31:0] exp_a;
        logic [19:0] exp_b;
        bit          exp_wrap_a, exp_wrap_b;
        int          len;
        for (int b = 0; b < 12; b++) begin
            model_clear();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len && !m_closed; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                put_beat(16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, i == len - 1);
                if (!m_closed) begin
                    n_checks++; if (a_out_valid !== 1'b0) begin n_fails++; $display("FAIL rand_open_valid[%0d.%0d]: got %b want 0", b, i, a_out_valid); end
                end
            end
            exp_a      = m_sum[31:0];
            exp_b      = m_sum[19:0];
            exp_wrap_a = (m_sum >= 64'h1_0000_0000);
            exp_wrap_b = (m_sum >= 64'h10_0000);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_checks++; if (a_out_valid !== 1'b1) begin n_fails++; $display("FAIL rand_valid[%0d]: got %b want 1", b, a_out_valid); end
            n_checks++; if (a_out_total !== exp_a || a_out_wrap !== exp_wrap_a) begin
                n_fails++;
                $display("FAIL rand_total_w32[%0d]: got %h/%b want %h/%b", b, a_out_total, a_out_wrap, exp_a, exp_wrap_a);
            end
            n_checks++; if (b_out_total !== exp_b || b_out_wrap !== exp_wrap_b) begin
                n_fails++;
                $display("FAIL rand_total_w20[%0d]: got %h/%b want %h/%b", b, b_out_total, b_out_wrap, exp_b, exp_wrap_b);
            end
            n_checks++; if (a_out_count !== 8'(m_count) || a_out_ovf !== m_ovf) begin
                n_fails++;
                $display("FAIL rand_count_ovf[%0d]: got %0d/%b want %0d/%b", b, a_out_count, a_out_ovf, m_count, m_ovf);
            end
            take_result();
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_overflow();
        test_auto_close();
        test_backpressure();
        test_reset_mid_burst();
        test_random_bursts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/add16_accumulator.md
# add16_accumulator

Result-side consumer for the 16-bit registered adder. It takes the adder's `sum`, `cout` and `overflow` as a stream of valid/ready beats and accumulates them into a wide running total. When a burst ends it presents one result word together with status flags. It sits directly downstream of the adder, which drives its `in_*` port.

## Interface
Parameters:
- `WIDTH`, 16, width of the incoming adder sum.
- `ACC_WIDTH`, 32, accumulator width. Must be at least WIDTH+1.
- `MAX_BEATS`, 16, beats per burst before the burst closes automatically. Range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block can accept a beat.
- `in_sum`  in  WIDTH  adder sum.
- `in_cout`  in  1  adder carry-out; forms bit WIDTH of the beat value.
- `in_overflow`  in  1  adder signed-overflow flag.
- `in_last`  in  1  final beat of the burst.
- `out_valid`  out  1  result word present.
- `out_ready`  in  1  downstream accepts the result.
- `out_total`  out  ACC_WIDTH  accumulated total, modulo 2^ACC_WIDTH.
- `out_count`  out  8  number of beats in the burst.
- `out_wrap`  out  1  accumulator carried out of bit ACC_WIDTH-1 at least once.
- `out_ovf_seen`  out  1  at least one beat had `in_overflow`=1.

## Operation
- Beat value: {in_cout, in_sum}, unsigned, WIDTH+1 bits, zero-extended to ACC_WIDTH.
- Beat is accepted when `in_valid` & `in_ready`.
- On each accepted beat:
  - acc <= acc + value, modulo 2^ACC_WIDTH.
  - count <= count + 1.
  - wrap is set if the add carries out of ACC_WIDTH.
  - ovf is set if `in_overflow`=1.
- Wrap and ovf are sticky for the whole burst.
- States:
  - IDLE: count=0. `in_ready`=1. An accepted beat goes to ACC, or to HOLD if the burst closes on that beat.
  - ACC: `in_ready`=1. A closing beat goes to HOLD.
  - HOLD: `in_ready`=0, `out_valid`=1. `out_valid`&`out_ready` clears acc, count, wrap and ovf, and goes to IDLE.
- A burst closes on an accepted beat with `in_last`=1, or on the beat that makes count==MAX_BEATS (`in_last` ignored there). The closing beat is included in the result.
- `out_total`, `out_count`, `out_wrap` and `out_ovf_seen` reflect the internal registers directly. They are stable for the whole time HOLD lasts.
- `in_ready` is decoded from the state register only; it has no combinational path from `out_ready`.
- Reset is asynchronous and takes effect mid-burst or mid-HOLD: state=IDLE and all accumulated data is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_total`=0, `out_count`=0, `out_wrap`=0, `out_ovf_seen`=0.
- Latency: closing beat accepted at edge N gives `out_valid`=1 after edge N, with the final total.
- Throughput: 1 beat/cycle in IDLE and ACC.
- One bubble per burst: the result handshake at edge M puts the block in IDLE after M, so `in_ready` is 1 from then on. No input beat can be accepted in the HOLD cycle where the handshake occurs.
- `out_ready` may stay high continuously; HOLD then lasts exactly 1 cycle.
- `in_valid` while `in_ready`=0: no state change. The upstream holds the beat.
- `out_valid` never deasserts without a handshake, except on reset.

## Test plan
- Single beat: `in_sum`=0x1234, `in_cout`=0, `in_last`=1 -> next cycle `out_valid`=1, `out_total`=0x00001234, `out_count`=1, both flags 0.
- Three back-to-back beats: `in_sum`=0xFFFF, `in_cout`=1, last on the 3rd -> `out_total`=0x0005FFFD, `out_count`=3. Next burst starts from 0.
- Overflow flag: 4 beats of 0x0010, `in_overflow`=1 on beat 2 only -> `out_total`=0x40, `out_ovf_seen`=1. The following burst reports `out_ovf_seen`=0.
- Auto-close at MAX_BEATS=16: 16 beats of 0x0001, `in_last`=0 -> `out_total`=0x10, `out_count`=16. Then with ACC_WIDTH=20: 16 beats of {1,0xFFFF} -> `out_total`=0xFFFF0, `out_wrap`=1.
- Backpressure: `out_ready`=0 for 5 HOLD cycles while `in_valid`=1 -> outputs constant, `in_ready`=0, no beat consumed. The handshake then returns to IDLE and the held beat is accepted next cycle.
- Reset mid-burst: drop `rst` for 1 cycle after 2 of 4 beats -> all outputs at reset values. A new 1-beat burst of 0x0005 gives `out_total`=5, `out_count`=1.
